// File: rtl/mul_arbiter.sv
//----------------------------------------------------------------------------
// Module  : mul_arbiter
// Shares one sequential multiplier between two requesters (round-robin, watchdog).
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

module mul_arbiter #(
    parameter int WIDTH       = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*WIDTH-1:0]   res0,
    output logic [2*WIDTH-1:0]   res1,
    output logic [WIDTH-1:0]     m_multiplier,
    output logic [WIDTH-1:0]     m_multiplicand,
    output logic                 m_op_start,
    output logic                 m_op_clear,
    input  logic                 m_op_done,
    input  logic [2*WIDTH-1:0]   m_result,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 winner_q, winner_d;
    logic [15:0]          wdog_q, wdog_d;
    logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                 done0_q, done0_d, done1_q, done1_d;
    logic [2*WIDTH-1:0]   res0_q, res0_d, res1_q, res1_d;
    logic [WIDTH-1:0]     mult_q, mult_d, mcand_q, mcand_d;
    logic                 start_q, start_d, clear_q, clear_d;
    logic                 busy_q, busy_d, terr_q, terr_d;
    logic                 w_win;
    logic                 w_finish;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            winner_q   <= 1'b0;
            wdog_q     <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            res0_q     <= '0;
            res1_q     <= '0;
            mult_q     <= '0;
            mcand_q    <= '0;
            start_q    <= 1'b0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            winner_q   <= winner_d;
            wdog_q     <= wdog_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            mult_q     <= mult_d;
            mcand_q    <= mcand_d;
            start_q    <= start_d;
            clear_q    <= clear_d;
            busy_q     <= busy_d;
            terr_q     <= terr_d;
        end
    end

    // With both requesting, the one not served last wins; otherwise the sole requester.
    assign w_win    = (req0 && req1) ? ~last_gnt_q : req1;
    assign w_finish = m_op_done || ((wdog_q + 16'd1) == c_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        winner_d   = winner_q;
        wdog_d     = wdog_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        res0_d     = res0_q;
        res1_d     = res1_q;
        mult_d     = mult_q;
        mcand_d    = mcand_q;
        start_d    = start_q;
        clear_d    = clear_q;
        terr_d     = terr_q;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    winner_d = w_win;
                    gnt0_d   = ~w_win;
                    gnt1_d   = w_win;
                    mult_d   = w_win ? a1 : a0;
                    mcand_d  = w_win ? b1 : b0;
                    start_d  = 1'b1;
                    wdog_d   = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + 16'd1;
                if (w_finish) begin
                    // A completed product always beats a watchdog expiring on the same cycle.
                    if (winner_q) res1_d = m_op_done ? m_result : '0;
                    else          res0_d = m_op_done ? m_result : '0;
                    if (!m_op_done) terr_d = 1'b1;
                    start_d = 1'b0;
                    clear_d = 1'b1;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clear_d = 1'b0;
                state_d = S_RESP;
            end
            default: begin
                done0_d    = ~winner_q;
                done1_d    = winner_q;
                last_gnt_d = winner_q;
                state_d    = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign gnt0           = gnt0_q;
    assign gnt1           = gnt1_q;
    assign done0          = done0_q;
    assign done1          = done1_q;
    assign res0           = res0_q;
    assign res1           = res1_q;
    assign m_multiplier   = mult_q;
    assign m_multiplicand = mcand_q;
    assign m_op_start     = start_q;
    assign m_op_clear     = clear_q;
    assign busy           = busy_q;
    assign timeout_err    = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
//----------------------------------------------------------------------------
// Module  : tb_mul_arbiter
// Randomized self-checking bench for mul_arbiter with a latency-programmable multiplier.
// Rev 1.0 : initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_mul_arbiter;

    localparam int W  = 64;
    localparam int TO = 255;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]     a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             gnt0, gnt1, done0, done1;
    logic [2*W-1:0]   res0, res1;
    logic [W-1:0]     m_multiplier, m_multiplicand;
    logic             m_op_start, m_op_clear;
    logic             m_op_done;
    logic [2*W-1:0]   m_result;
    logic             busy, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int lat   = 1;
    int mcnt  = 0;
    int ref_last = 1;
    bit ref_err  = 1'b0;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res0(res0), .res1(res1),
        .m_multiplier(m_multiplier), .m_multiplicand(m_multiplicand),
        .m_op_start(m_op_start), .m_op_clear(m_op_clear),
        .m_op_done(m_op_done), .m_result(m_result),
        .busy(busy), .timeout_err(timeout_err)
    );

    function automatic logic [2*W-1:0] sprod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] sx, sy;
        sx = $signed({{W{x[W-1]}}, x});
        sy = $signed({{W{y[W-1]}}, y});
        return sx * sy;
    endfunction

    // Behavioural multiplier: op_done rises on the lat-th cycle of op_start (lat=0: never).
    always @(posedge clk) begin
        if (!m_op_start) mcnt <= 0;
        else             mcnt <= mcnt + 1;
    end

    always_comb begin
        m_op_done = m_op_start && (lat > 0) && (mcnt == lat - 1);
        m_result  = sprod(m_multiplier, m_multiplicand);
    end

    task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        ref_last = 1;
        ref_err  = 1'b0;
    endtask

    task automatic run_job(input bit r0, input bit r1,
                           input logic [W-1:0] x0, input logic [W-1:0] y0,
                           input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input int l, input bit keep);
        int  win, t, k, clears, extra, exp_k;
        bit  exp_to;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        req0 = r0; req1 = r1; lat = l;
        win    = (r0 && r1) ? 1 - ref_last : (r1 ? 1 : 0);
        exp_to = (l == 0) || (l > TO);
        exp_k  = exp_to ? TO : l;

        t = 0;
        while (!(gnt0 || gnt1) && t < 400) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 400) begin
            chk("gnt_wait", 0, 1);
            return;
        end
        chk("gnt_vec", {gnt1, gnt0}, win ? 2 : 1);
        chk("m_multiplier", m_multiplier, win ? x1 : x0);
        chk("m_multiplicand", m_multiplicand, win ? y1 : y0);
        if (!keep) begin
            req0 = 1'b0; req1 = 1'b0;
            a0 = ~x0; b0 = ~y0; a1 = ~x1; b1 = ~y1;
        end

        k = m_op_start ? 1 : 0;
        clears = 0; extra = 0; t = 0;
        while (!(done0 || done1) && t < 400) begin
            @(posedge clk); #1; t++;
            if (m_op_start) k++;
            if (m_op_clear) clears++;
            if (gnt0 || gnt1) extra++;
        end
        if (exp_to) ref_err = 1'b1;
        chk("run_cycles", k, exp_k);
        chk("clear_pulses", clears, 1);
        chk("stray_gnt", extra, 0);
        chk("done_latency", t, exp_k + 2);
        chk("done_vec", {done1, done0}, win ? 2 : 1);
        chk("res", win ? res1 : res0, exp_to ? '0 : sprod(win ? x1 : x0, win ? y1 : y0));
        chk("timeout_err", timeout_err, ref_err);
        ref_last = win;
        @(posedge clk); #1;
        chk("done_pulse", {done1, done0}, 0);
    endtask

    initial begin
        logic [W-1:0] m19, m1;
        int seen_done;
        bit rr0, rr1;
        m19 = 64'hFFFF_FFFF_FFFF_FFED;
        m1  = '1;

        // Reset values
        do_reset();
        #1;
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_done", {done1, done0}, 0);
        chk("rst_res0", res0, 0);
        chk("rst_res1", res1, 0);
        chk("rst_mult", {m_multiplier, m_multiplicand}, 0);
        chk("rst_start_clear", {m_op_start, m_op_clear}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);

        // Single requester, long latency
        run_job(1, 0, m19, m19, 64'd0, 64'd0, 70, 0);
        chk("res0_169", res0, 128'h169);

        // Continuous contention alternates
        do_reset();
        for (int i = 0; i < 4; i++)
            run_job(1, 1, m19, m19, 64'd3, 64'd5, 3 + i, (i < 3));
        chk("res1_F", res1, 128'hF);

        // Done coincides with watchdog limit: done wins
        run_job(0, 1, 64'd7, 64'd9, 64'd11, 64'd13, TO, 0);

        // Watchdog abort, then a good job keeps the sticky error
        run_job(1, 0, 64'd4, 64'd6, 64'd0, 64'd0, 0, 0);
        run_job(1, 0, 64'd4, 64'd6, 64'd0, 64'd0, 9, 0);

        // Reset mid-RUN loses the job
        a0 = 64'd2; b0 = 64'd2; req0 = 1'b1; lat = 70;
        seen_done = 0;
        for (int t = 0; t < 100 && !(gnt0 || gnt1); t++) begin
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        repeat (29) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_start", m_op_start, 0);
        chk("rst_mid_busy", busy, 0);
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (done0 || done1) seen_done++;
        end
        @(negedge clk);
        reset_n = 1'b1; ref_last = 1; ref_err = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(posedge clk); #1;
            if (done0 || done1) seen_done++;
        end
        chk("rst_no_done", seen_done, 0);
        run_job(0, 1, 64'd0, 64'd0, m1, m1, 5, 0);
        chk("res1_one", res1, 128'h1);

        // Randomized traffic
        for (int i = 0; i < 25; i++) begin
            rr0 = 1'($urandom_range(0, 1));
            rr1 = 1'($urandom_range(0, 1));
            if (!rr0 && !rr1) rr0 = 1'b1;
            run_job(rr0, rr1,
                    {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom},
                    (i == 12) ? 0 : int'($urandom_range(1, 30)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
